// File: rtl/nibble_serial_sub_ctrl_pkg.sv
// Shared constants for the nibble-serial subtract controller and its slice.
package nibble_serial_sub_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Nibble counter width: clog2(n), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_ctrl_bls4_slice.sv
// 4-bit borrow-lookahead subtract slice: diff = a - b - bin, purely combinational.
module bls4_slice
  import nibble_serial_sub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] diff,
  output logic                bout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Subtraction as a + ~b + ~bin; lookahead carries are the inverted borrows.
  assign p = a ~^ b;
  assign g = a & ~b;

  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign diff = p ^ c[3:0];
  assign bout = ~c[4];

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Multi-cycle W-bit subtractor: Diff = X - Y - Bin, one nibble per cycle LSB first
// through a single shared borrow-lookahead slice.
module nibble_serial_sub_ctrl
  import nibble_serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] X,
  input  logic [NIBBLE_W*NIBBLES-1:0] Y,
  input  logic                        Bin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] Diff,
  output logic                        Bout,
  output logic                        zero,
  output logic                        ovf
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned CW = cnt_width(NIBBLES);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          borrow_q, borrow_d;
  logic          xmsb_q, xmsb_d;
  logic          ymsb_q, ymsb_d;
  logic          bout_q, bout_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] sl_diff;
  logic                sl_bout;
  logic [W-1:0]        acc_next;

  bls4_slice u_slice (
    .a    (x_q[NIBBLE_W-1:0]),
    .b    (y_q[NIBBLE_W-1:0]),
    .bin  (borrow_q),
    .diff (sl_diff),
    .bout (sl_bout)
  );

  // New nibble enters at the MSB end; written as shifts so NIBBLES=1 stays legal.
  assign acc_next = (acc_q >> NIBBLE_W) | (W'(sl_diff) << (W - NIBBLE_W));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    xmsb_d   = xmsb_q;
    ymsb_d   = ymsb_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          x_d      = X;
          y_d      = Y;
          borrow_d = Bin;
          xmsb_d   = X[W-1];
          ymsb_d   = Y[W-1];
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d    = acc_next;
        borrow_d = sl_bout;
        x_d      = x_q >> NIBBLE_W;
        y_d      = y_q >> NIBBLE_W;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(NIBBLES - 1)) begin
          state_d = ST_DONE;
          diff_d  = acc_next;
          bout_d  = sl_bout;
          zero_d  = (acc_next == '0);
          ovf_d   = (xmsb_q != ymsb_q) && (acc_next[W-1] != xmsb_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      xmsb_q   <= 1'b0;
      ymsb_q   <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      xmsb_q   <= xmsb_d;
      ymsb_q   <= ymsb_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Directed bench for nibble_serial_sub_ctrl (default NIBBLES=4, 16-bit operands).
module tb_nibble_serial_sub_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] X;
  logic [15:0] Y;
  logic        Bin;
  logic        busy;
  logic        done;
  logic [15:0] Diff;
  logic        Bout;
  logic        zero;
  logic        ovf;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [15:0] prev_diff;

  nibble_serial_sub_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive start for one cycle; returns at the falling edge of cycle 1.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic b);
    @(negedge clk);
    start = 1'b1;
    X     = x;
    Y     = y;
    Bin   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full operation with latency, hold-while-busy and result checks.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic b, input logic [15:0] ed, input logic eb,
                        input logic ez, input logic eo);
    issue(x, y, b);
    for (int i = 1; i <= 4; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      if (i == 1 || i == 4) check({tag, "_hold"}, 32'(Diff), 32'(prev_diff));
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy5"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(Diff), 32'(ed));
    check({tag, "_bout"}, 32'(Bout), 32'(eb));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_keep"}, 32'(Diff), 32'(ed));
    prev_diff = ed;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    prev_diff = 16'h0000;
    rst   = 1'b1;
    start = 1'b1;
    X     = 16'hFFFF;
    Y     = 16'h0001;
    Bin   = 1'b1;

    // Reset held two edges with start asserted alongside.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(Diff), 32'h0000);
    check("rst_bout", 32'(Bout), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    check("rst_noaccept", 32'(busy), 32'd0);

    run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("negov", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    run_op("zerob", 16'h00FF, 16'h00FE, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("posov", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);

    // Start re-pulsed while busy must be ignored.
    issue(16'h5555, 16'h1111, 1'b0);
    start = 1'b1;
    X     = 16'hFFFF;
    Y     = 16'h0000;
    Bin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ign_done", 32'(done), 32'd1);
    check("ign_diff", 32'(Diff), 32'h4444);
    check("ign_bout", 32'(Bout), 32'd0);

    // Back-to-back: start during the done cycle.
    start = 1'b1;
    X     = 16'h0010;
    Y     = 16'h0001;
    Bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_nodone", 32'(done), 32'd0);
      @(negedge clk);
    end
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_diff", 32'(Diff), 32'h000F);
    check("b2b_zero", 32'(zero), 32'd0);
    @(negedge clk);
    prev_diff = 16'h000F;

    // Reset in cycle 3 of RUN aborts without a done pulse.
    issue(16'h9999, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(Diff), 32'h0000);
    check("abort_bout", 32'(Bout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'd0);
    end
    prev_diff = 16'h0000;
    run_op("fresh", 16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
